// File: rtl/sample_func_if.sv
// Message/status bundle for the sample_func pairwise factor node.
// The slave modport is the factor node; the master side drives messages and Stop.
interface sample_func_if;
    logic       Stop;
    logic [7:0] varA0In;
    logic [7:0] varA1In;
    logic [7:0] varB0In;
    logic [7:0] varB1In;
    logic [7:0] funA0;
    logic [7:0] funA1;
    logic [7:0] funB0;
    logic [7:0] funB1;
    logic       Busy;
    logic       Updated;
    logic       Converged;
    logic [7:0] Iter;

    modport master (
        output Stop, varA0In, varA1In, varB0In, varB1In,
        input  funA0, funA1, funB0, funB1, Busy, Updated, Converged, Iter
    );

    modport slave (
        input  Stop, varA0In, varA1In, varB0In, varB1In,
        output funA0, funA1, funB0, funB1, Busy, Updated, Converged, Iter
    );
endinterface

// File: rtl/sample_func.sv
// Pairwise min-sum factor node with a fixed 2x2 cost table, 5-cycle capture-to-idle pipeline.
// Optional SAMPLE_FUNC_DAMP_EN: outputs are damped as (old+new+1)>>1 instead of written directly.
module sample_func #(
    parameter logic [7:0] P00 = 8'd0,
    parameter logic [7:0] P01 = 8'd4,
    parameter logic [7:0] P10 = 8'd4,
    parameter logic [7:0] P11 = 8'd0
) (
    input logic          Clk,
    input logic          Reset,
    sample_func_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StSum, StMin, StNorm, StUpd} state_e;

    // Indexed [x][y]: x is the A state, y is the B state.
    localparam logic [1:0][1:0][7:0] Cost = {P11, P10, P01, P00};

    state_e state_q, state_d;
    logic   capture;
    logic   dirty_q;

    logic [1:0][7:0]      in_a, in_b;
    logic [1:0][7:0]      cap_a_q, cap_b_q;
    logic [1:0][1:0][7:0] cand_a_q, cand_b_q;
    logic [1:0][7:0]      min_a_q, min_b_q;
    logic [1:0][7:0]      norm_a_q, norm_b_q;
    logic [1:0][7:0]      wr_a, wr_b;
    logic [1:0][7:0]      fun_a_q, fun_b_q;
    logic                 updated_q, converged_q;
    logic [7:0]           iter_q;

    function automatic logic [7:0] sat_add(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] min8(input logic [7:0] x, input logic [7:0] y);
        return (x < y) ? x : y;
    endfunction

    assign in_a = {bus.varA1In, bus.varA0In};
    assign in_b = {bus.varB1In, bus.varB0In};

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!bus.Stop && (dirty_q || in_a != cap_a_q || in_b != cap_b_q)) begin
                    capture = 1'b1;
                    state_d = StSum;
                end
            end
            StSum:   state_d = StMin;
            StMin:   state_d = StNorm;
            StNorm:  state_d = StUpd;
            StUpd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Value written at UPD; the damped form blends with the current output.
    always_comb begin
        wr_a = norm_a_q;
        wr_b = norm_b_q;
`ifdef SAMPLE_FUNC_DAMP_EN
        for (int i = 0; i < 2; i++) begin
            wr_a[i] = 8'((9'(fun_a_q[i]) + 9'(norm_a_q[i]) + 9'd1) >> 1);
            wr_b[i] = 8'((9'(fun_b_q[i]) + 9'(norm_b_q[i]) + 9'd1) >> 1);
        end
`else
        wr_a = norm_a_q;
        wr_b = norm_b_q;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            dirty_q     <= 1'b1;
            cap_a_q     <= '0;
            cap_b_q     <= '0;
            fun_a_q     <= '0;
            fun_b_q     <= '0;
            updated_q   <= 1'b0;
            converged_q <= 1'b0;
            iter_q      <= '0;
        end else begin
            state_q   <= state_d;
            updated_q <= 1'b0;
            if (capture) begin
                cap_a_q <= in_a;
                cap_b_q <= in_b;
                dirty_q <= 1'b0;
            end
            if (state_q == StUpd) begin
                fun_a_q     <= wr_a;
                fun_b_q     <= wr_b;
                updated_q   <= 1'b1;
                converged_q <= (wr_a == fun_a_q) && (wr_b == fun_b_q);
                if (iter_q != 8'hFF) begin
                    iter_q <= iter_q + 8'd1;
                end
            end
        end
    end

    // Datapath stages; contents are only consumed in their matching FSM state.
    always_ff @(posedge Clk) begin
        if (state_q == StSum) begin
            for (int x = 0; x < 2; x++) begin
                for (int y = 0; y < 2; y++) begin
                    cand_a_q[x][y] <= sat_add(Cost[x][y], cap_b_q[y]);
                    cand_b_q[x][y] <= sat_add(Cost[x][y], cap_a_q[x]);
                end
            end
        end
        if (state_q == StMin) begin
            for (int i = 0; i < 2; i++) begin
                min_a_q[i] <= min8(cand_a_q[i][0], cand_a_q[i][1]);
                min_b_q[i] <= min8(cand_b_q[0][i], cand_b_q[1][i]);
            end
        end
        if (state_q == StNorm) begin
            for (int i = 0; i < 2; i++) begin
                norm_a_q[i] <= min_a_q[i] - min8(min_a_q[0], min_a_q[1]);
                norm_b_q[i] <= min_b_q[i] - min8(min_b_q[0], min_b_q[1]);
            end
        end
    end

    assign bus.funA0     = fun_a_q[0];
    assign bus.funA1     = fun_a_q[1];
    assign bus.funB0     = fun_b_q[0];
    assign bus.funB1     = fun_b_q[1];
    assign bus.Busy      = (state_q != StIdle);
    assign bus.Updated   = updated_q;
    assign bus.Converged = converged_q;
    assign bus.Iter      = iter_q;

endmodule
